// File: rtl/syn_fft_pkg.sv
// Shared definitions for the PCM frame buffer and the downstream FFT FSM.
// Holds the frame size both sides agree on and the buffer FSM encoding.
package syn_fft_pkg;

    localparam int P_NUM_SAMPLES = 128;

    typedef enum logic [0:0] {
        FILL_S = 1'b0,
        WAIT_S = 1'b1
    } pcm_buf_fsm_t;

endpackage

// File: rtl/syn_pcm_dpram.sv
// Simple 1W/1R block RAM with a registered read port.
// The read register only advances on rd_en, so it holds the last word otherwise.
module syn_pcm_dpram #(
    parameter int P_ADDR_W = 8,
    parameter int P_DATA_W = 32
) (
    input  logic                clk,
    input  logic                we,
    input  logic [P_ADDR_W-1:0] waddr,
    input  logic [P_DATA_W-1:0] wdata,
    input  logic                rd_en,
    input  logic [P_ADDR_W-1:0] raddr,
    output logic [P_DATA_W-1:0] rdata
);

    logic [P_DATA_W-1:0] mem [2**P_ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/syn_pcm_frame_buf.sv
// Ping-pong stereo PCM frame buffer feeding the FFT FSM.
// One bank fills from the PCM stream while the other is read by the consumer.
module syn_pcm_frame_buf
    import syn_fft_pkg::*;
#(
    parameter int P_NUM_SAMPLES = syn_fft_pkg::P_NUM_SAMPLES,
    parameter int P_PCM_DATA_W  = 32,
    parameter int P_MEM_RD_DEL  = 2
) (
    input  logic                                   clk_ir,
    input  logic                                   rst_ih,
    input  logic                                   pcm_valid_ih,
    input  logic [P_PCM_DATA_W-1:0]                pcm_lchnnl_ih,
    input  logic [P_PCM_DATA_W-1:0]                pcm_rchnnl_ih,
    input  logic                                   fft_done_ih,
    input  logic                                   ovfl_clr_ih,
    output logic                                   pcm_rdy_oh,
    input  logic                                   lchnnl_rd_en_ih,
    input  logic [$clog2(P_NUM_SAMPLES)-1:0]       lchnnl_addr_ih,
    output logic [P_PCM_DATA_W-1:0]                lchnnl_rdata_od,
    output logic                                   lchnnl_rd_valid_od,
    input  logic                                   rchnnl_rd_en_ih,
    input  logic [$clog2(P_NUM_SAMPLES)-1:0]       rchnnl_addr_ih,
    output logic [P_PCM_DATA_W-1:0]                rchnnl_rdata_od,
    output logic                                   rchnnl_rd_valid_od,
    output logic                                   ovfl_oh,
    output logic [15:0]                            frame_cnt_od
);

    localparam int P_ADDR_W = $clog2(P_NUM_SAMPLES);

    pcm_buf_fsm_t          state_f, state_next;
    logic                  wbank_f, wbank_next;
    logic [P_ADDR_W-1:0]   waddr_f, waddr_next;
    logic                  rd_full_f, rd_full_next;
    logic                  ovfl_f, ovfl_next;
    logic [15:0]           frame_cnt_f, frame_cnt_next;

    logic wr_fire;
    logic wr_last;
    logic bank_free;
    logic drop;

    assign wr_fire   = pcm_valid_ih && (state_f == FILL_S);
    assign wr_last   = (waddr_f == P_ADDR_W'(P_NUM_SAMPLES - 1));
    assign bank_free = ~rd_full_f | fft_done_ih;
    assign drop      = pcm_valid_ih && (state_f == WAIT_S);

    always_comb begin
        state_next     = state_f;
        wbank_next     = wbank_f;
        waddr_next     = waddr_f;
        rd_full_next   = rd_full_f;
        frame_cnt_next = frame_cnt_f;
        case (state_f)
            FILL_S: begin
                // Release first so a same-cycle swap can re-set the full flag.
                if (fft_done_ih) begin
                    rd_full_next = 1'b0;
                end
                if (wr_fire) begin
                    if (wr_last) begin
                        waddr_next     = '0;
                        frame_cnt_next = frame_cnt_f + 16'd1;
                        if (bank_free) begin
                            wbank_next   = ~wbank_f;
                            rd_full_next = 1'b1;
                        end else begin
                            state_next = WAIT_S;
                        end
                    end else begin
                        waddr_next = waddr_f + P_ADDR_W'(1);
                    end
                end
            end
            WAIT_S: begin
                // The held write bank becomes the read bank; the read side stays full.
                if (fft_done_ih) begin
                    wbank_next = ~wbank_f;
                    state_next = FILL_S;
                end
            end
            default: state_next = FILL_S;
        endcase
        ovfl_next = drop ? 1'b1 : (ovfl_clr_ih ? 1'b0 : ovfl_f);
    end

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            state_f     <= FILL_S;
            wbank_f     <= 1'b0;
            waddr_f     <= '0;
            rd_full_f   <= 1'b0;
            ovfl_f      <= 1'b0;
            frame_cnt_f <= '0;
        end else begin
            state_f     <= state_next;
            wbank_f     <= wbank_next;
            waddr_f     <= waddr_next;
            rd_full_f   <= rd_full_next;
            ovfl_f      <= ovfl_next;
            frame_cnt_f <= frame_cnt_next;
        end
    end

    assign pcm_rdy_oh   = rd_full_f;
    assign ovfl_oh      = ovfl_f;
    assign frame_cnt_od = frame_cnt_f;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic                    ren;
            logic [P_ADDR_W-1:0]     raddr;
            logic [P_PCM_DATA_W-1:0] wdata;
            logic [P_PCM_DATA_W-1:0] ram_q;
            logic [P_PCM_DATA_W-1:0] rdata_f;
            logic [P_MEM_RD_DEL-1:0] vld_sr;

            if (gi == 0) begin : g_l
                assign ren   = lchnnl_rd_en_ih;
                assign raddr = lchnnl_addr_ih;
                assign wdata = pcm_lchnnl_ih;
            end else begin : g_r
                assign ren   = rchnnl_rd_en_ih;
                assign raddr = rchnnl_addr_ih;
                assign wdata = pcm_rchnnl_ih;
            end

            syn_pcm_dpram #(
                .P_ADDR_W (P_ADDR_W + 1),
                .P_DATA_W (P_PCM_DATA_W)
            ) u_ram (
                .clk   (clk_ir),
                .we    (wr_fire),
                .waddr ({wbank_f, waddr_f}),
                .wdata (wdata),
                .rd_en (ren),
                .raddr ({~wbank_f, raddr}),
                .rdata (ram_q)
            );

            always_ff @(posedge clk_ir or posedge rst_ih) begin
                if (rst_ih) begin
                    vld_sr  <= '0;
                    rdata_f <= '0;
                end else begin
                    vld_sr <= {vld_sr[P_MEM_RD_DEL-2:0], ren};
                    if (vld_sr[0]) begin
                        rdata_f <= ram_q;
                    end
                end
            end
        end
    endgenerate

    assign lchnnl_rdata_od    = g_ch[0].rdata_f;
    assign lchnnl_rd_valid_od = g_ch[0].vld_sr[P_MEM_RD_DEL-1];
    assign rchnnl_rdata_od    = g_ch[1].rdata_f;
    assign rchnnl_rd_valid_od = g_ch[1].vld_sr[P_MEM_RD_DEL-1];

endmodule
